// File: rtl/vm_pkg.sv
// Shared vending-machine definitions.
// Coin values and the change-dispenser state encoding.
package vm_pkg;

  localparam int COIN_NICKEL = 5;
  localparam int COIN_DIME   = 10;

  typedef enum logic [2:0] {
    CD_IDLE,
    CD_SEL,
    CD_EJ_D,
    CD_EJ_N,
    CD_DONE,
    CD_FAULT
  } cd_state_t;

endpackage

// File: rtl/change_dispenser_eject_timer.sv
// Ejector acknowledge watchdog.
// Flags expiry on the TMO-th consecutive enabled cycle.
module eject_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TMO + 1);
  localparam logic [W-1:0] LAST = W'(TMO - 1);

  logic [W-1:0] count;

  // count = cycles already spent waiting before the current one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays change as dimes then nickels.
// Handshakes each coin with the ejector and tracks stock.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int CHANGE_W    = 5,
  parameter int CNT_W       = 6,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 20,
  parameter int ACK_TMO     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dispense,
  input  logic [CHANGE_W-1:0] change,
  input  logic                eject_ack,
  input  logic                refill,
  output logic                eject_nickel,
  output logic                eject_dime,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                overrun,
  output logic [CHANGE_W-1:0] owed,
  output logic [CNT_W-1:0]    nickel_cnt,
  output logic [CNT_W-1:0]    dime_cnt
);

  localparam logic [CHANGE_W-1:0] C_N = CHANGE_W'(COIN_NICKEL);
  localparam logic [CHANGE_W-1:0] C_D = CHANGE_W'(COIN_DIME);
  localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cd_state_t           state;
  cd_state_t           state_n;
  logic [CHANGE_W-1:0] owed_n;
  logic [CNT_W-1:0]    ncnt_n;
  logic [CNT_W-1:0]    dcnt_n;
  logic                in_ej;
  logic                expired;

  assign in_ej = (state == CD_EJ_D) || (state == CD_EJ_N);

  eject_timer #(
    .TMO(ACK_TMO)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_ej),
    .enable (in_ej),
    .expired(expired)
  );

  // next state, owed and stock; refill overrides any ack decrement
  always_comb begin
    state_n = state;
    owed_n  = owed;
    ncnt_n  = nickel_cnt;
    dcnt_n  = dime_cnt;
    unique case (state)
      CD_IDLE: begin
        if (dispense) begin
          if (change >= C_N) begin
            state_n = CD_SEL;
            owed_n  = change;
          end else begin
            state_n = CD_DONE;
          end
        end
      end
      CD_SEL: begin
        unique case (1'b1)
          (owed >= C_D) && (dime_cnt != '0):
            state_n = CD_EJ_D;
          (owed >= C_N) && (nickel_cnt != '0)
            && !((owed >= C_D) && (dime_cnt != '0)):
            state_n = CD_EJ_N;
          (owed < C_N):
            state_n = CD_DONE;
          default:
            state_n = CD_FAULT;
        endcase
      end
      CD_EJ_D: begin
        if (eject_ack) begin
          owed_n  = owed - C_D;
          dcnt_n  = dime_cnt - ONE;
          state_n = CD_SEL;
        end else if (expired) begin
          state_n = CD_FAULT;
        end
      end
      CD_EJ_N: begin
        if (eject_ack) begin
          owed_n  = owed - C_N;
          ncnt_n  = nickel_cnt - ONE;
          state_n = CD_SEL;
        end else if (expired) begin
          state_n = CD_FAULT;
        end
      end
      CD_DONE: begin
        owed_n  = '0;
        state_n = CD_IDLE;
      end
      CD_FAULT: begin
        if (refill) begin
          owed_n  = '0;
          state_n = CD_IDLE;
        end
      end
      default: begin
        owed_n  = '0;
        state_n = CD_IDLE;
      end
    endcase
    if (refill) begin
      ncnt_n = N_INIT;
      dcnt_n = D_INIT;
    end
  end

  // FSM state, datapath and Moore outputs decoded ahead into flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CD_IDLE;
      owed         <= '0;
      nickel_cnt   <= N_INIT;
      dime_cnt     <= D_INIT;
      eject_dime   <= 1'b0;
      eject_nickel <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      owed         <= owed_n;
      nickel_cnt   <= ncnt_n;
      dime_cnt     <= dcnt_n;
      eject_dime   <= (state_n == CD_EJ_D);
      eject_nickel <= (state_n == CD_EJ_N);
      busy         <= (state_n == CD_SEL) || (state_n == CD_EJ_D)
                   || (state_n == CD_EJ_N) || (state_n == CD_DONE);
      done         <= (state_n == CD_DONE);
      fault        <= (state_n == CD_FAULT);
      overrun      <= dispense && (state != CD_IDLE);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser.
// Random transactions against an arithmetic payout model.
module tb_change_dispenser;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dispense = 1'b0;
  logic [4:0] change = '0;
  logic       eject_ack = 1'b0;
  logic       refill = 1'b0;
  logic       eject_nickel, eject_dime, busy, done, fault, overrun;
  logic [4:0] owed;
  logic [5:0] nickel_cnt, dime_cnt;

  change_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .dispense    (dispense),
    .change      (change),
    .eject_ack   (eject_ack),
    .refill      (refill),
    .eject_nickel(eject_nickel),
    .eject_dime  (eject_dime),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .overrun     (overrun),
    .owed        (owed),
    .nickel_cnt  (nickel_cnt),
    .dime_cnt    (dime_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 dime eject, 1 nickel eject, 2 done, 3 fault
  typedef struct {
    int kind;
    int owed;
    int n;
    int d;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  m_n = 20;
  int  m_d = 20;

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // greedy payout; coin number 'drop' is never acknowledged
  function automatic void model(input int chg, input int drop);
    int  ow;
    int  k;
    bit  fin;
    ev_t e;
    if (chg < 5) begin
      e = '{2, 0, m_n, m_d};
      exp_q.push_back(e);
      return;
    end
    ow  = chg;
    k   = 0;
    fin = 0;
    while (!fin) begin
      if ((ow >= 10 && m_d > 0) || (ow >= 5 && m_n > 0)) begin
        if (ow >= 10 && m_d > 0) e = '{0, ow, m_n, m_d};
        else e = '{1, ow, m_n, m_d};
        exp_q.push_back(e);
        if (k == drop) begin
          e = '{3, ow, m_n, m_d};
          exp_q.push_back(e);
          fin = 1;
        end else if (ow >= 10 && m_d > 0) begin
          ow -= 10;
          m_d--;
        end else begin
          ow -= 5;
          m_n--;
        end
        k++;
      end else if (ow < 5) begin
        e = '{2, 0, m_n, m_d};
        exp_q.push_back(e);
        fin = 1;
      end else begin
        e = '{3, ow, m_n, m_d};
        exp_q.push_back(e);
        fin = 1;
      end
    end
  endfunction

  task automatic pop_chk(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected event", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event kind", kind, e.kind);
    if (kind != 2) chk("event owed", int'(owed), e.owed);
    chk("event nickels", int'(nickel_cnt), e.n);
    chk("event dimes", int'(dime_cnt), e.d);
    if (kind < 2) chk("eject overlap", int'(eject_dime & eject_nickel), 0);
  endtask

  logic pd = 1'b0;
  logic pn = 1'b0;
  logic pf = 1'b0;

  // monitor: every new output event is matched against the queue head
  always @(negedge clk) begin
    if (reset) begin
      if (eject_dime && !pd) pop_chk(0);
      if (eject_nickel && !pn) pop_chk(1);
      if (done) pop_chk(2);
      if (fault && !pf) pop_chk(3);
    end
    pd <= eject_dime;
    pn <= eject_nickel;
    pf <= fault;
  end

  task automatic do_refill();
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m_n = 20;
    m_d = 20;
  endtask

  task automatic run_txn(input int chg, input int drop, input bit ovr);
    int coin;
    int cyc;
    int hi;
    int ow;
    bit finished;
    bit faulted;
    model(chg, drop);
    @(negedge clk);
    dispense = 1'b1;
    change   = 5'(chg);
    @(negedge clk);
    dispense = 1'b0;
    coin = 0;
    cyc = 0;
    finished = 0;
    faulted = 0;
    while (!finished && cyc < 400) begin
      if (done || fault) begin
        finished = 1;
        faulted  = fault;
      end else if (eject_dime || eject_nickel) begin
        if (coin == drop) begin
          hi = 0;
          while ((eject_dime || eject_nickel) && hi < 100) begin
            hi++;
            @(negedge clk);
            cyc++;
          end
          chk("eject high cycles", hi, TMO);
        end else begin
          if (ovr && coin == 0) begin
            ow = int'(owed);
            dispense = 1'b1;
            change = 5'($urandom_range(0, 31));
            @(negedge clk);
            dispense = 1'b0;
            cyc++;
            chk("overrun pulse", int'(overrun), 1);
            chk("owed during overrun", int'(owed), ow);
          end
          repeat ($urandom_range(0, 4)) begin
            @(negedge clk);
            cyc++;
          end
          eject_ack = 1'b1;
          @(negedge clk);
          eject_ack = 1'b0;
          cyc++;
          coin++;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) chk("transaction timeout", 0, 1);
    if (faulted) begin
      do_refill();
      chk("refill clears fault", int'(fault), 0);
      chk("refill nickels", int'(nickel_cnt), 20);
      chk("refill dimes", int'(dime_cnt), 20);
    end
    @(negedge clk);
    chk("idle owed", int'(owed), 0);
    chk("idle busy", int'(busy), 0);
    chk("queue drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int w;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset eject", int'(eject_dime | eject_nickel), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset nickels", int'(nickel_cnt), 20);
    chk("reset dimes", int'(dime_cnt), 20);
    chk("reset owed", int'(owed), 0);
    chk("reset fault", int'(fault), 0);

    run_txn(10, -1, 0);
    run_txn(15, -1, 0);
    run_txn(20, 1, 1);

    // asynchronous reset in the middle of a nickel request
    model(5, -1);
    @(negedge clk);
    dispense = 1'b1;
    change   = 5'd5;
    @(negedge clk);
    dispense = 1'b0;
    w = 0;
    while (!eject_nickel && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("nickel request seen", int'(eject_nickel), 1);
    #2 reset = 1'b0;
    #1;
    chk("async eject drop", int'(eject_nickel), 0);
    chk("async owed", int'(owed), 0);
    chk("async busy", int'(busy), 0);
    chk("async nickels", int'(nickel_cnt), 20);
    exp_q.delete();
    m_n = 20;
    m_d = 20;
    @(negedge clk);
    reset = 1'b1;
    run_txn(3, -1, 0);

    repeat (20) run_txn(10, -1, 0);
    run_txn(20, -1, 0);
    repeat (3) run_txn(25, -1, 0);
    run_txn(10, -1, 0);

    for (int i = 0; i < 40; i++) begin
      int dr;
      if ($urandom_range(0, 14) == 0) begin
        @(negedge clk);
        do_refill();
      end
      dr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(int'($urandom_range(0, 31)), dr, ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
